// File: rtl/laser_shot.sv
// Player laser: spawns above the ship on a fire edge, climbs one step per frame, then cools down.
// Outputs are registered. color has one cycle of latency from hPos/vPos. There is no backpressure.
module laser_shot #(
   parameter int SCREEN_HEIGHT   = 480,
   parameter int SHIP_HEIGHT     = 75,
   parameter int LASER_WIDTH     = 2,
   parameter int LASER_LENGTH    = 10,
   parameter int LASER_STEP      = 8,
   parameter int COOLDOWN_FRAMES = 4,
   parameter logic [2:0] LASER   = 3'd6,
   parameter logic [2:0] NONE    = 3'd7
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       fire,
   input  logic       frame_tick,
   input  logic [9:0] gunPosition,
   input  logic [9:0] hPos,
   input  logic [9:0] vPos,
   input  logic       hit,
   output logic [9:0] laserX,
   output logic [9:0] laserY,
   output logic       active,
   output logic       miss,
   output logic [2:0] color
);

   typedef enum logic [1:0] {IDLE, FLYING, COOLDOWN} state_t;

   localparam logic [9:0]  SPAWN_Y = 10'(SCREEN_HEIGHT - SHIP_HEIGHT - LASER_LENGTH);
   localparam logic [9:0]  HALF_W  = 10'(LASER_WIDTH / 2);
   localparam logic [9:0]  STEP    = 10'(LASER_STEP);
   localparam int          CW      = (COOLDOWN_FRAMES < 2) ? 1 : $clog2(COOLDOWN_FRAMES + 1);
   localparam logic [CW-1:0] CD_LOAD = CW'(COOLDOWN_FRAMES);
   localparam logic [10:0] W11     = 11'(LASER_WIDTH);
   localparam logic [10:0] L11     = 11'(LASER_LENGTH);

   state_t          state_q, state_d;
   logic [9:0]      x_q, x_d;
   logic [9:0]      y_q, y_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            fire_q;
   logic            miss_q, miss_d;
   logic [2:0]      color_q, color_d;

   logic            shot_req;
   logic            in_x, in_y;

   // fire_q resets high so a button held through reset is not taken as an edge
   assign shot_req = fire & ~fire_q;

   // 11-bit compares so the right/bottom edge cannot wrap past 1023
   assign in_x = ({1'b0, hPos} >= {1'b0, x_q}) && ({1'b0, hPos} < ({1'b0, x_q} + W11));
   assign in_y = ({1'b0, vPos} >= {1'b0, y_q}) && ({1'b0, vPos} < ({1'b0, y_q} + L11));

   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      cnt_d   = cnt_q;
      miss_d  = 1'b0;
      color_d = (state_q == FLYING && in_x && in_y) ? LASER : NONE;
      case (state_q)
         IDLE: begin
            if (shot_req) begin
               state_d = FLYING;
               x_d     = gunPosition - HALF_W;
               y_d     = SPAWN_Y;
            end
         end
         FLYING: begin
            if (hit) begin
               state_d = COOLDOWN;
               cnt_d   = CD_LOAD;
            end else if (frame_tick) begin
               if (y_q >= STEP) begin
                  y_d = y_q - STEP;
               end else begin
                  state_d = COOLDOWN;
                  cnt_d   = CD_LOAD;
                  miss_d  = 1'b1;
               end
            end
         end
         COOLDOWN: begin
            if (cnt_q == '0) begin
               state_d = IDLE;
            end else if (frame_tick) begin
               cnt_d = cnt_q - 1'b1;
               if (cnt_q == CW'(1)) state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         x_q     <= '0;
         y_q     <= '0;
         cnt_q   <= '0;
         fire_q  <= 1'b1;
         miss_q  <= 1'b0;
         color_q <= NONE;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
         cnt_q   <= cnt_d;
         fire_q  <= fire;
         miss_q  <= miss_d;
         color_q <= color_d;
      end
   end

   assign laserX = x_q;
   assign laserY = y_q;
   assign active = (state_q == FLYING);
   assign miss   = miss_q;
   assign color  = color_q;

endmodule

// File: tb/tb_laser_shot.sv
// Self-checking bench for laser_shot: directed scenarios with literal expectations plus
// a randomized run, all compared every cycle against a behavioural model.
module tb_laser_shot;

   localparam int M_IDLE = 0, M_FLY = 1, M_COOL = 2;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       fire = 1'b1;
   logic       frame_tick = 1'b0;
   logic [9:0] gunPosition = 10'd0;
   logic [9:0] hPos = 10'd0;
   logic [9:0] vPos = 10'd0;
   logic       hit = 1'b0;
   logic [9:0] laserX, laserY;
   logic       active, miss;
   logic [2:0] color;

   int errors = 0;
   int checks = 0;

   // behavioural model state
   int  m_mode = M_IDLE;
   int  m_x = 0, m_y = 0;
   int  m_ticks = 0;
   int  m_prev_fire = 1;
   int  m_miss = 0;
   int  m_color = 7;
   bit  m_valid = 1'b0;

   laser_shot dut (
      .clk(clk), .reset(reset), .fire(fire), .frame_tick(frame_tick),
      .gunPosition(gunPosition), .hPos(hPos), .vPos(vPos), .hit(hit),
      .laserX(laserX), .laserY(laserY), .active(active), .miss(miss), .color(color)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // One clock of the spec's rules, applied to the inputs present at the edge.
   task automatic model_step();
      int on_pixel;
      if (reset) begin
         m_mode = M_IDLE; m_x = 0; m_y = 0; m_ticks = 0;
         m_prev_fire = 1; m_miss = 0; m_color = 7; m_valid = 1'b1;
         return;
      end
      on_pixel = (m_mode == M_FLY) && (int'(hPos) >= m_x) && (int'(hPos) < m_x + 2)
                 && (int'(vPos) >= m_y) && (int'(vPos) < m_y + 10);
      m_color = on_pixel ? 6 : 7;
      m_miss = 0;
      if (m_mode == M_IDLE) begin
         if (fire && !m_prev_fire) begin
            m_mode = M_FLY;
            m_x = (int'(gunPosition) + 1024 - 1) % 1024;
            m_y = 480 - 75 - 10;
         end
      end else if (m_mode == M_FLY) begin
         if (hit) begin
            m_mode = M_COOL; m_ticks = 0;
         end else if (frame_tick) begin
            if (m_y >= 8) m_y = m_y - 8;
            else begin
               m_mode = M_COOL; m_ticks = 0; m_miss = 1;
            end
         end
      end else begin
         if (frame_tick) begin
            m_ticks++;
            if (m_ticks == 4) m_mode = M_IDLE;
         end
      end
      m_prev_fire = int'(fire);
   endtask

   always @(negedge clk) begin
      if (m_valid) begin
         check("active", int'(active), int'(m_mode == M_FLY));
         check("laserX", int'(laserX), m_x);
         check("laserY", int'(laserY), m_y);
         check("miss",   int'(miss),   m_miss);
         check("color",  int'(color),  m_color);
      end
   end

   task automatic cyc();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic tick();
      frame_tick = 1'b1; cyc(); frame_tick = 1'b0; cyc();
   endtask

   task automatic fire_edge();
      fire = 1'b0; cyc(); fire = 1'b1; cyc();
   endtask

   // four cooldown frames; fire edges before the last one must be ignored
   task automatic cooldown_probe(input string tag);
      for (int k = 1; k <= 4; k++) begin
         fire_edge();
         check($sformatf("%s_ignored_%0d", tag, k), int'(active), 0);
         tick();
      end
      fire_edge();
      check({tag, "_reshot"}, int'(active), 1);
   endtask

   initial begin
      repeat (3) cyc();
      check("rst_active", int'(active), 0);
      check("rst_laserX", int'(laserX), 0);
      check("rst_laserY", int'(laserY), 0);
      check("rst_miss",   int'(miss), 0);
      check("rst_color",  int'(color), 7);

      reset = 1'b0;
      repeat (5) cyc();
      check("held_fire_no_shot", int'(active), 0);

      gunPosition = 10'd320;
      fire_edge();
      check("shot_active", int'(active), 1);
      check("shot_laserX", int'(laserX), 319);
      check("shot_laserY", int'(laserY), 395);

      gunPosition = 10'd500;
      repeat (100) cyc();
      check("no_repeat_laserX", int'(laserX), 319);
      check("no_repeat_laserY", int'(laserY), 395);

      hPos = 10'd320; vPos = 10'd400; cyc(); check("pix_in",        int'(color), 6);
      hPos = 10'd321;                 cyc(); check("pix_right",     int'(color), 7);
      hPos = 10'd319; vPos = 10'd404; cyc(); check("pix_corner",    int'(color), 6);
      vPos = 10'd405;                 cyc(); check("pix_below",     int'(color), 7);
      hPos = 10'd320; vPos = 10'd394; cyc(); check("pix_above",     int'(color), 7);

      repeat (49) tick();
      check("climb_laserY", int'(laserY), 3);
      check("climb_active", int'(active), 1);
      frame_tick = 1'b1; cyc(); frame_tick = 1'b0;
      check("miss_pulse",  int'(miss), 1);
      check("miss_active", int'(active), 0);
      check("miss_laserY", int'(laserY), 3);
      hPos = 10'd320; vPos = 10'd5; cyc();
      check("miss_one_cycle", int'(miss), 0);
      check("pix_not_flying", int'(color), 7);

      cooldown_probe("miss_cd");
      check("reshot_laserX", int'(laserX), 499);

      tick(); tick();
      hit = 1'b1; frame_tick = 1'b1; cyc(); hit = 1'b0; frame_tick = 1'b0;
      check("hit_active", int'(active), 0);
      check("hit_laserY", int'(laserY), 379);
      check("hit_no_miss", int'(miss), 0);
      cooldown_probe("hit_cd");

      tick();
      reset = 1'b1; cyc(); cyc();
      check("midflight_rst_active", int'(active), 0);
      check("midflight_rst_color",  int'(color), 7);
      reset = 1'b0;
      repeat (10) cyc();
      check("post_rst_no_shot", int'(active), 0);
      fire_edge();
      check("post_rst_shot", int'(active), 1);

      for (int i = 0; i < 5000; i++) begin
         if ($urandom_range(0, 3) == 0) fire = ~fire;
         frame_tick  = ($urandom_range(0, 5) == 0);
         hit         = ($urandom_range(0, 19) == 0);
         reset       = ($urandom_range(0, 399) == 0);
         if ($urandom_range(0, 7) == 0) gunPosition = 10'($urandom_range(0, 1023));
         if ($urandom_range(0, 1) == 0) begin
            hPos = 10'(m_x + int'($urandom_range(0, 4)) - 1);
            vPos = 10'(m_y + int'($urandom_range(0, 12)) - 1);
         end else begin
            hPos = 10'($urandom_range(0, 1023));
            vPos = 10'($urandom_range(0, 1023));
         end
         cyc();
      end
      reset = 1'b0; frame_tick = 1'b0; hit = 1'b0;
      cyc(); cyc();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/laser_shot.md
LASER_SHOT -- requirements
Module: laser_shot

Interface
REQ-001 The block SHALL have the following parameters, one per line: name, default, meaning.
- SCREEN_HEIGHT, 480, visible lines
- SHIP_HEIGHT, 75, ship height in pixels; laser spawns above it
- LASER_WIDTH, 2, laser width in pixels
- LASER_LENGTH, 10, laser height in pixels
- LASER_STEP, 8, pixels moved up per frame_tick
- COOLDOWN_FRAMES, 4, frames before next shot allowed
- LASER, 6, color code for a laser pixel
- NONE, 7, color code for no laser pixel
REQ-002 The block SHALL have these ports, one per line: name, direction, width, meaning.
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  reset, synchronous, active-high
- fire  in  1  fire button level, already synchronised
- frame_tick  in  1  one-cycle pulse once per frame
- gunPosition  in  10  ship centre x, from spaceship block
- hPos  in  10  current pixel x
- vPos  in  10  current pixel y
- hit  in  1  one-cycle pulse from alien block: laser struck an alien
- laserX  out  10  laser left edge x
- laserY  out  10  laser top edge y
- active  out  1  high while laser in flight
- miss  out  1  one-cycle pulse: laser left top of screen
- color  out  3  LASER or NONE for current pixel

Function
REQ-003 The block SHALL implement a state machine with states IDLE, FLYING, COOLDOWN; active SHALL be 1 exactly in FLYING.
REQ-004 A shot SHALL be requested only by a rising edge of fire (fire=1 while the previous-cycle registered fire=0); holding fire SHALL NOT auto-repeat.
REQ-005 In IDLE on a shot request, the next cycle SHALL have state FLYING, laserX=gunPosition-LASER_WIDTH/2 (mod 1024), laserY=SCREEN_HEIGHT-SHIP_HEIGHT-LASER_LENGTH (395 default).
REQ-006 Shot requests in FLYING or COOLDOWN SHALL be ignored and not queued.
REQ-007 In FLYING, on frame_tick with no hit: if laserY >= LASER_STEP, laserY SHALL decrease by LASER_STEP; otherwise state SHALL go to COOLDOWN, miss SHALL pulse for one cycle, laserY unchanged.
REQ-008 In FLYING, hit=1 SHALL move state to COOLDOWN next cycle regardless of frame_tick; hit SHALL take priority over frame_tick in the same cycle; miss SHALL stay 0.
REQ-009 hit outside FLYING SHALL be ignored.
REQ-010 On entry to COOLDOWN a frame counter SHALL load COOLDOWN_FRAMES; each frame_tick in COOLDOWN SHALL decrement it; frame_tick while counter=1 SHALL return state to IDLE (exactly COOLDOWN_FRAMES ticks spent); COOLDOWN_FRAMES=0 SHALL return to IDLE on the first cycle after entry.
REQ-011 laserX SHALL be held constant for the whole flight (does not track gunPosition).
REQ-012 color SHALL be registered with one-cycle latency: LASER when active and laserX <= hPos < laserX+LASER_WIDTH and laserY <= vPos < laserY+LASER_LENGTH; else NONE.
REQ-013 Range comparisons SHALL use at least 11-bit unsigned arithmetic so laserX+LASER_WIDTH and laserY+LASER_LENGTH do not wrap.

Reset
REQ-014 While reset=1: state IDLE, laserX=0, laserY=0, active=0, miss=0, color=NONE, cooldown counter=0, registered fire=1 (fire held across reset release SHALL NOT fire).
REQ-015 reset SHALL override all other inputs, including mid-flight and mid-cooldown.

Verification
REQ-016 gunPosition=320, fire 0->1 in IDLE -> next cycle active=1, laserX=319, laserY=395; fire held 100 cycles -> no second shot.
REQ-017 In flight at laserY=395, 49 frame_ticks -> laserY=3; next tick -> miss pulses once, active=0, laserY=3.
REQ-018 In flight, hit and frame_tick same cycle -> COOLDOWN, laserY unchanged, miss=0; fire edges during next 4 frame_ticks ignored; fire edge after 4th tick -> new shot.
REQ-019 laserX=319, laserY=200, active: hPos=320,vPos=205 -> color=LASER one cycle later; hPos=321 or vPos=210 -> NONE; same pixel when idle -> NONE.
REQ-020 reset asserted mid-flight with fire held high -> IDLE, active=0, color=NONE; after release no shot until fire drops and rises.
